// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// mult_share_arbiter : round-robin sharing of one sequential 16x16 multiplier
// Revision: 1.0
// ============================================================================
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_product,
  output logic                 rsp_err,
  output logic                 mul_start,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic                 mul_ready,
  input  logic [31:0]          mul_product,
  output logic                 busy
);

  localparam int CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] C_CNT_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_gnt;
  logic [IDW-1:0]  r_last;
  logic [CNTW-1:0] r_cnt;
  logic [15:0]     r_mul_a;
  logic [15:0]     r_mul_b;
  logic [31:0]     r_prod;
  logic            r_err;

  logic            w_found;
  logic [IDW-1:0]  w_gnt;
  logic [15:0]     w_a;
  logic [15:0]     w_b;
  int              w_idx;

  // Cyclic search starting just after the last requester served.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_a     = '0;
    w_b     = '0;
    w_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = int'(r_last) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[IDW-1:0];
        w_a     = req_a[16*w_idx +: 16];
        w_b     = req_b[16*w_idx +: 16];
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    mul_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready[w_gnt] = 1'b1;
          w_next           = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        mul_start = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (mul_ready || (r_cnt == C_CNT_LAST)) w_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_last  <= IDW'(NREQ - 1);
      r_cnt   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_prod  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_gnt;
            r_mul_a <= w_a;
            r_mul_b <= w_b;
          end
        end
        S_LAUNCH: r_cnt <= '0;
        S_WAIT: begin
          // A done pulse coinciding with the final watchdog count still wins.
          if (mul_ready) begin
            r_prod <= mul_product;
            r_err  <= 1'b0;
          end else if (r_cnt == C_CNT_LAST) begin
            r_prod <= '0;
            r_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) r_last <= r_gnt;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_id      = r_gnt;
  assign rsp_product = r_prod;
  assign rsp_err     = r_err;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mult_share_arbiter : directed bench with a 16-cycle multiplier model
// Revision: 1.0
// ============================================================================
module tb_mult_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [16*NREQ-1:0] req_a = '0;
  logic [16*NREQ-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_product;
  logic              rsp_err;
  logic              mul_start;
  logic [15:0]       mul_a;
  logic [15:0]       mul_b;
  logic              mul_ready;
  logic [31:0]       mul_product;
  logic              busy;

  logic              m_rdy = 1'b0;
  logic              t_rdy = 1'b0;
  logic              m_en  = 1'b1;
  int                m_cnt = 0;
  logic [15:0]       m_a = '0;
  logic [15:0]       m_b = '0;
  logic [31:0]       m_prod = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mul_ready   = m_rdy | t_rdy;
  assign mul_product = m_prod;

  mult_share_arbiter #(.NREQ(NREQ), .TIMEOUT(64), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product),
    .busy(busy)
  );

  // Multiplier model: done pulse during the 16th cycle after start.
  always @(posedge clk) begin
    m_rdy <= 1'b0;
    if (mul_start) begin
      m_cnt <= 1;
      m_a   <= mul_a;
      m_b   <= mul_b;
    end else if (m_cnt != 0) begin
      if (m_cnt == 15) begin
        m_cnt <= 0;
        if (m_en) begin
          m_rdy  <= 1'b1;
          m_prod <= 32'($signed(m_a) * $signed(m_b));
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!rsp_valid && cyc < 200);
  endtask

  // Starts in IDLE with req_valid already applied; ends in IDLE after handshake.
  task automatic run_job(input int g, input logic [15:0] ea, input logic [31:0] ep,
                         input logic [3:0] v_after);
    int cyc;
    logic [3:0] oh;
    oh = 4'b0001 << g;
    #1;
    chk("grant", 32'(req_ready), 32'(oh));
    tick();
    chk("start", 32'(mul_start), 32'd1);
    chk("mul_a", 32'(mul_a), 32'(ea));
    req_valid = v_after;
    wait_rsp(cyc);
    chk("latency", 32'(cyc), 32'd17);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("product", rsp_product, ep);
    chk("err", 32'(rsp_err), 32'd0);
    tick();
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int cyc;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_product", rsp_product, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    rst = 1'b1;
    tick();

    // Single request from 0: 3 * -2
    req_a[15:0] = 16'h0003;
    req_b[15:0] = 16'hFFFE;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("t1_mul_start_idle", 32'(mul_start), 32'd0);
    run_job(0, 16'h0003, 32'hFFFFFFFA, 4'b0000);
    chk("t1_mul_b", 32'(mul_b), 32'h0000FFFE);

    // All four requesting continuously after reset
    do_reset();
    req_a = {16'h0028, 16'h001E, 16'h0014, 16'h000A};
    req_b = {16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
    req_valid = 4'b1111;
    run_job(0, 16'h000A, 32'hFFFFFFEC, 4'b1111);
    run_job(1, 16'h0014, 32'hFFFFFFD8, 4'b1111);
    run_job(2, 16'h001E, 32'hFFFFFFC4, 4'b1111);
    run_job(3, 16'h0028, 32'hFFFFFFB0, 4'b1111);
    run_job(0, 16'h000A, 32'hFFFFFFEC, 4'b0000);

    // Fairness: 2 and 3 alternate; 1 arriving during a job of 3 goes next
    do_reset();
    req_valid = 4'b1100;
    run_job(2, 16'h001E, 32'hFFFFFFC4, 4'b1100);
    run_job(3, 16'h0028, 32'hFFFFFFB0, 4'b1100);
    run_job(2, 16'h001E, 32'hFFFFFFC4, 4'b1100);
    run_job(3, 16'h0028, 32'hFFFFFFB0, 4'b1110);
    run_job(1, 16'h0014, 32'hFFFFFFD8, 4'b1100);
    run_job(2, 16'h001E, 32'hFFFFFFC4, 4'b0000);

    // Timeout: multiplier never answers
    m_en = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk("to_grant", 32'(req_ready), 32'h1);
    tick();
    chk("to_start", 32'(mul_start), 32'd1);
    req_valid = 4'b0000;
    wait_rsp(cyc);
    chk("to_latency", 32'(cyc), 32'd65);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_product", rsp_product, 32'd0);
    chk("to_id", 32'(rsp_id), 32'd0);
    t_rdy = 1'b1;
    tick();
    t_rdy = 1'b0;
    tick();
    chk("to_hold_valid", 32'(rsp_valid), 32'd1);
    chk("to_hold_err", 32'(rsp_err), 32'd1);
    chk("to_hold_product", rsp_product, 32'd0);
    rsp_ready = 1'b1;
    tick();
    chk("to_drop", 32'(rsp_valid), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);

    // Backpressure: requester 1, 0x100 * 0x100
    m_en = 1'b1;
    rsp_ready = 1'b0;
    req_a[31:16] = 16'h0100;
    req_b[31:16] = 16'h0100;
    req_valid = 4'b0010;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h2);
    tick();
    chk("bp_start", 32'(mul_start), 32'd1);
    req_valid = 4'b0000;
    wait_rsp(cyc);
    chk("bp_latency", 32'(cyc), 32'd17);
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_product", rsp_product, 32'h00010000);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_drop", 32'(rsp_valid), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'h4);
    req_valid = 4'b0000;

    // Reset asserted while waiting on the multiplier
    m_en = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk("rw_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    chk("rw_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_mul_a", 32'(mul_a), 32'd0);
    chk("rw_mul_b", 32'(mul_b), 32'd0);
    chk("rw_product", rsp_product, 32'd0);
    chk("rw_id", 32'(rsp_id), 32'd0);
    chk("rw_valid", 32'(rsp_valid), 32'd0);
    tick();
    rst = 1'b1;
    t_rdy = 1'b1;
    tick();
    t_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rw_stale_valid", 32'(rsp_valid), 32'd0);
    end
    chk("rw_stale_busy", 32'(busy), 32'd0);
    m_en = 1'b1;
    req_a[15:0] = 16'h0003;
    req_b[15:0] = 16'hFFFE;
    req_valid = 4'b1111;
    run_job(0, 16'h0003, 32'hFFFFFFFA, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
